// File: rtl/div_pkg.sv
// Shared types and defaults for the divider request issuer.
// The saturated quotient is sliced from an all-ones constant to the active width.
package div_pkg;

  localparam int DEF_W       = 4;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 15;

  localparam logic [63:0] SAT_QUOT_ALL = {64{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/div_op_fifo.sv
// Operand queue: power-of-two ring buffer with registered full/empty flags.
// A push into a full queue is accepted when a pop happens in the same cycle.
module div_op_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          empty_r;

  logic          do_push_s;
  logic          do_pop_s;
  logic [CW-1:0] count_nxt_s;

  // Qualify push/pop and compute the next occupancy.
  always_comb begin
    do_pop_s    = pop && !empty_r;
    do_push_s   = push && (!full_r || do_pop_s);
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage, pointers and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/div_req_issuer.sv
// Feeds queued operand pairs to an external divider one at a time and holds
// each result (normal, divide-by-zero or timeout) until the consumer takes it.
module div_req_issuer
  import div_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         div_start,
  output logic [W-1:0] div_x,
  output logic [W-1:0] div_y,
  input  logic         div_valid,
  input  logic [W-1:0] div_quot,
  input  logic [W-1:0] div_rem,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_quot,
  output logic [W-1:0] res_rem,
  output logic         res_dbz,
  output logic         res_tmo
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [W-1:0]  SAT_Q    = SAT_QUOT_ALL[W-1:0];

  state_t        state_r;
  logic          in_ready_en_r;
  logic          div_start_r;
  logic [W-1:0]  div_x_r;
  logic [W-1:0]  div_y_r;
  logic          res_valid_r;
  logic [W-1:0]  res_quot_r;
  logic [W-1:0]  res_rem_r;
  logic          res_dbz_r;
  logic          res_tmo_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          dv_prev_r;

  logic          push_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [2*W-1:0] head_s;
  logic [W-1:0]  head_x_s;
  logic [W-1:0]  head_y_s;
  logic          done_s;

  assign push_s   = in_valid && in_ready;
  assign pop_s    = (state_r == ST_IDLE) && !fifo_empty_s;
  assign head_x_s = head_s[2*W-1:W];
  assign head_y_s = head_s[W-1:0];
  // Only a rising edge counts, so a level left high from earlier is ignored.
  assign done_s   = div_valid && !dv_prev_r;

  div_op_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data ({in_x, in_y}),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Issue/wait/hold sequencer with all outward signals registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      in_ready_en_r <= 1'b0;
      div_start_r   <= 1'b0;
      div_x_r       <= {W{1'b0}};
      div_y_r       <= {W{1'b0}};
      res_valid_r   <= 1'b0;
      res_quot_r    <= {W{1'b0}};
      res_rem_r     <= {W{1'b0}};
      res_dbz_r     <= 1'b0;
      res_tmo_r     <= 1'b0;
      tmo_cnt_r     <= {TW{1'b0}};
      dv_prev_r     <= 1'b0;
    end else begin
      in_ready_en_r <= 1'b1;
      dv_prev_r     <= div_valid;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            div_x_r <= head_x_s;
            div_y_r <= head_y_s;
            if (head_y_s == {W{1'b0}}) begin
              res_quot_r  <= SAT_Q;
              res_rem_r   <= head_x_s;
              res_dbz_r   <= 1'b1;
              res_tmo_r   <= 1'b0;
              res_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
            end else begin
              div_start_r <= 1'b1;
              state_r     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          div_start_r <= 1'b0;
          tmo_cnt_r   <= {TW{1'b0}};
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_s) begin
            res_quot_r  <= div_quot;
            res_rem_r   <= div_rem;
            res_dbz_r   <= 1'b0;
            res_tmo_r   <= 1'b0;
            res_valid_r <= 1'b1;
            tmo_cnt_r   <= {TW{1'b0}};
            state_r     <= ST_HOLD;
          end else if (tmo_cnt_r == TMO_LAST) begin
            res_quot_r  <= SAT_Q;
            res_rem_r   <= {W{1'b0}};
            res_dbz_r   <= 1'b0;
            res_tmo_r   <= 1'b1;
            res_valid_r <= 1'b1;
            tmo_cnt_r   <= {TW{1'b0}};
            state_r     <= ST_HOLD;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            res_quot_r  <= {W{1'b0}};
            res_rem_r   <= {W{1'b0}};
            res_dbz_r   <= 1'b0;
            res_tmo_r   <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          div_start_r <= 1'b0;
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_en_r && !fifo_full_s;
  assign div_start = div_start_r;
  assign div_x     = div_x_r;
  assign div_y     = div_y_r;
  assign res_valid = res_valid_r;
  assign res_quot  = res_quot_r;
  assign res_rem   = res_rem_r;
  assign res_dbz   = res_dbz_r;
  assign res_tmo   = res_tmo_r;

endmodule
